// File: rtl/note_pkg.sv
// Shared note definitions: note codes, frequency table and period helpers for the tone path.
// Pure elaboration-time content; no latency and no flow control.
package note_pkg;

  typedef enum logic [3:0] {
    NOTE_NONE = 4'd0,
    NOTE_B4,
    NOTE_C5,
    NOTE_DS5,
    NOTE_E5,
    NOTE_F5,
    NOTE_FS5,
    NOTE_G5,
    NOTE_GS5,
    NOTE_A5,
    NOTE_B5,
    NOTE_C6,
    NOTE_E6,
    NOTE_G6
  } note_e;

  localparam int NUM_NOTES = 13;

  typedef enum logic [1:0] {
    ST_SILENT,
    ST_ACQUIRE,
    ST_LOCKED
  } det_state_e;

  // Integer Hz per note code; the music player's tone table reads the same values.
  function automatic int unsigned note_hz(input logic [3:0] code);
    case (code)
      4'd1:    return 493;
      4'd2:    return 523;
      4'd3:    return 622;
      4'd4:    return 659;
      4'd5:    return 698;
      4'd6:    return 740;
      4'd7:    return 784;
      4'd8:    return 831;
      4'd9:    return 880;
      4'd10:   return 987;
      4'd11:   return 1046;
      4'd12:   return 1318;
      4'd13:   return 1568;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned note_period(input int unsigned clk_hz, input logic [3:0] code);
    int unsigned hz;
    hz = note_hz(code);
    if (hz == 0) return 0;
    return clk_hz / hz;
  endfunction

  // Toggle interval used by sound_generator to synthesise the square wave.
  function automatic int unsigned note_half_period(input int unsigned clk_hz, input logic [3:0] code);
    return note_period(clk_hz, code) / 2;
  endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational period -> note code classifier with +/- nom/64 tolerance window per note.
// Zero latency (registered by the parent); no flow control.
module note_period_lut
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int          PERIOD_W       = 22,
  parameter int unsigned TIMEOUT_CYCLES = 2_097_152
) (
  input  logic [PERIOD_W-1:0] meas,
  output logic [3:0]          code
);

  localparam logic [PERIOD_W-1:0] TIMEOUT = PERIOD_W'(TIMEOUT_CYCLES);

  logic [NUM_NOTES:1] hit;

  for (genvar c = 1; c <= NUM_NOTES; c++) begin : g_code
    localparam int unsigned NOM = note_period(CLK_HZ, 4'(c));
    localparam int unsigned TOL = NOM >> 6;
    localparam logic [PERIOD_W-1:0] LO = PERIOD_W'(NOM - TOL);
    localparam logic [PERIOD_W-1:0] HI = PERIOD_W'(NOM + TOL);
    assign hit[c] = (meas >= LO) && (meas <= HI);
  end

  // Windows never overlap, so at most one hit bit is set.
  always_comb begin
    code = NOTE_NONE;
    if (meas < TIMEOUT) begin
      for (int c = 1; c <= NUM_NOTES; c++) begin
        if (hit[c]) code = 4'(c);
      end
    end
  end

endmodule

// File: rtl/note_detector.sv
// Measures the period of an async square wave and decodes it to a song note with hysteresis and silence timeout.
// Latency: tone_in rise -> note/note_change 5 clk; no backpressure, outputs are free-running levels/strobes.
module note_detector
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int          PERIOD_W       = 22,
  parameter int          STABLE_COUNT   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2_097_152
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tone_in,
  output logic [3:0]          note,
  output logic                note_valid,
  output logic                note_change,
  output logic [PERIOD_W-1:0] period
);

  localparam logic [PERIOD_W-1:0] TIMEOUT = PERIOD_W'(TIMEOUT_CYCLES);
  localparam int                  MC_W    = $clog2(STABLE_COUNT + 1);
  localparam logic [MC_W-1:0]     MC_MAX  = MC_W'(STABLE_COUNT);

  logic                sync1, sync2, sync3;
  logic                rise;
  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] meas;
  logic                at_timeout;
  logic [3:0]          lut_code;
  logic [3:0]          cand;
  logic                cand_vld;

  det_state_e          state, state_next;
  logic [3:0]          note_next;
  logic                change_next;
  logic [MC_W-1:0]     match_cnt, mc_next;
  logic [3:0]          prev_cand, prev_next;

  assign meas       = count + PERIOD_W'(1);
  assign at_timeout = (count == TIMEOUT);
  assign note_valid = (note != NOTE_NONE);

  note_period_lut #(
    .CLK_HZ        (CLK_HZ),
    .PERIOD_W      (PERIOD_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_lut (
    .meas(meas),
    .code(lut_code)
  );

  // Input path, period counter and candidate register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      rise     <= 1'b0;
      count    <= '0;
      cand     <= NOTE_NONE;
      cand_vld <= 1'b0;
      period   <= '0;
    end else begin
      sync1    <= tone_in;
      sync2    <= sync1;
      sync3    <= sync2;
      rise     <= sync2 & ~sync3;
      cand_vld <= rise && (state != ST_SILENT);
      if (rise) begin
        count <= '0;
      end else if (!at_timeout) begin
        count <= count + PERIOD_W'(1);
      end
      // The first edge out of silence only opens the measurement window.
      if (rise && (state != ST_SILENT)) begin
        period <= meas;
        cand   <= lut_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_SILENT;
      note        <= NOTE_NONE;
      note_change <= 1'b0;
      match_cnt   <= '0;
      prev_cand   <= NOTE_NONE;
    end else begin
      state       <= state_next;
      note        <= note_next;
      note_change <= change_next;
      match_cnt   <= mc_next;
      prev_cand   <= prev_next;
    end
  end

  always_comb begin
    state_next  = state;
    note_next   = note;
    change_next = 1'b0;
    mc_next     = match_cnt;
    prev_next   = prev_cand;

    // An edge arriving on the timeout cycle takes precedence over silence.
    if (rise) begin
      if (state == ST_SILENT) state_next = ST_ACQUIRE;
    end else if (at_timeout) begin
      state_next  = ST_SILENT;
      note_next   = NOTE_NONE;
      mc_next     = '0;
      change_next = (note != NOTE_NONE);
    end

    if (cand_vld) begin
      if (cand == prev_cand) begin
        mc_next = (match_cnt == MC_MAX) ? MC_MAX : match_cnt + MC_W'(1);
      end else begin
        mc_next   = MC_W'(1);
        prev_next = cand;
      end
      if ((mc_next >= MC_MAX) && (cand != note)) begin
        note_next   = cand;
        change_next = 1'b1;
      end
      state_next = (cand != NOTE_NONE) ? ST_LOCKED : ST_ACQUIRE;
    end
  end

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector at CLK_HZ=1 MHz, TIMEOUT_CYCLES=8192 (A5 nom 1136, B4 nom 2028).
module tb_note_detector;

  localparam int PW = 22;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tone_in = 1'b0;
  logic [3:0]    note;
  logic          note_valid;
  logic          note_change;
  logic [PW-1:0] period;

  int   total = 0;
  int   bad = 0;
  int   pulse_cnt = 0;
  int   zero_cnt = 0;
  logic watch_zero = 1'b0;

  always #5 clk = ~clk;

  note_detector #(
    .CLK_HZ        (1_000_000),
    .PERIOD_W      (PW),
    .STABLE_COUNT  (3),
    .TIMEOUT_CYCLES(8192)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tone_in    (tone_in),
    .note       (note),
    .note_valid (note_valid),
    .note_change(note_change),
    .period     (period)
  );

  always @(negedge clk) begin
    if (note_change === 1'b1) pulse_cnt++;
    if (watch_zero && note === 4'd0) zero_cnt++;
  end

  // n full periods, each starting with a rise; consecutive calls keep rises evenly spaced.
  task automatic tone_periods(input int per, input int n);
    for (int i = 0; i < n; i++) begin
      tone_in = 1'b1;
      repeat (per / 2) @(negedge clk);
      tone_in = 1'b0;
      repeat (per - per / 2) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    tone_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tone_in = ~tone_in;
      @(negedge clk);
      total++;
      if (note !== 4'd0 || note_valid !== 1'b0 || note_change !== 1'b0 || period !== '0) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: note=%0d valid=%b chg=%b period=%0d, want all 0",
                 i, note, note_valid, note_change, period);
      end
    end
    reset   = 1'b0;
    tone_in = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (note !== 4'd0 || note_valid !== 1'b0 || period !== '0) begin
      bad++;
      $display("FAIL reset_idle: note=%0d valid=%b period=%0d, want 0 0 0", note, note_valid, period);
    end
  endtask

  task automatic test_lock;
    int p0;
    p0 = pulse_cnt;
    tone_periods(1136, 2);
    total++;
    if (period !== 22'd1136) begin
      bad++;
      $display("FAIL lock_period: got %0d want 1136", period);
    end
    total++;
    if (note !== 4'd0) begin
      bad++;
      $display("FAIL lock_early: note=%0d want 0", note);
    end
    tone_periods(1136, 1);
    tone_in = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (note !== 4'd0) begin
      bad++;
      $display("FAIL lock_lat_before: note=%0d want 0", note);
    end
    @(negedge clk);
    total++;
    if (note !== 4'd9 || note_change !== 1'b1 || note_valid !== 1'b1) begin
      bad++;
      $display("FAIL lock_lat: note=%0d chg=%b valid=%b want 9 1 1", note, note_change, note_valid);
    end
    repeat (568 - 5) @(negedge clk);
    tone_in = 1'b0;
    repeat (568) @(negedge clk);
    tone_periods(1136, 1);
    total++;
    if (note !== 4'd9 || period !== 22'd1136) begin
      bad++;
      $display("FAIL lock_hold: note=%0d period=%0d want 9 1136", note, period);
    end
    total++;
    if (pulse_cnt - p0 !== 1) begin
      bad++;
      $display("FAIL lock_pulses: got %0d want 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_hysteresis;
    int p0;
    p0 = pulse_cnt;
    tone_periods(1150, 3);
    tone_periods(1160, 1);
    total++;
    if (note !== 4'd9 || period !== 22'd1150) begin
      bad++;
      $display("FAIL hyst_in_tol: note=%0d period=%0d want 9 1150", note, period);
    end
    total++;
    if (pulse_cnt !== p0) begin
      bad++;
      $display("FAIL hyst_no_pulse: got %0d pulses want 0", pulse_cnt - p0);
    end
    tone_periods(1160, 3);
    total++;
    if (note !== 4'd0 || note_valid !== 1'b0 || period !== 22'd1160) begin
      bad++;
      $display("FAIL hyst_out_tol: note=%0d valid=%b period=%0d want 0 0 1160", note, note_valid, period);
    end
    total++;
    if (pulse_cnt - p0 !== 1) begin
      bad++;
      $display("FAIL hyst_pulses: got %0d want 1", pulse_cnt - p0);
    end
    tone_periods(1136, 4);
    total++;
    if (note !== 4'd9) begin
      bad++;
      $display("FAIL hyst_relock: note=%0d want 9", note);
    end
  endtask

  task automatic test_switch;
    int p0;
    int z0;
    p0 = pulse_cnt;
    z0 = zero_cnt;
    watch_zero = 1'b1;
    tone_periods(2028, 3);
    total++;
    if (note !== 4'd9 || period !== 22'd2028) begin
      bad++;
      $display("FAIL switch_hold: note=%0d period=%0d want 9 2028", note, period);
    end
    tone_in = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (note !== 4'd9) begin
      bad++;
      $display("FAIL switch_lat_before: note=%0d want 9", note);
    end
    @(negedge clk);
    total++;
    if (note !== 4'd1 || note_change !== 1'b1) begin
      bad++;
      $display("FAIL switch_lat: note=%0d chg=%b want 1 1", note, note_change);
    end
    repeat (1014 - 5) @(negedge clk);
    tone_in = 1'b0;
    repeat (1014) @(negedge clk);
    watch_zero = 1'b0;
    total++;
    if (zero_cnt !== z0) begin
      bad++;
      $display("FAIL switch_no_zero: saw note=0 on %0d cycles want 0", zero_cnt - z0);
    end
    total++;
    if (pulse_cnt - p0 !== 1) begin
      bad++;
      $display("FAIL switch_pulses: got %0d want 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_silence;
    int p0;
    tone_periods(1136, 4);
    total++;
    if (note !== 4'd9) begin
      bad++;
      $display("FAIL silence_lock: note=%0d want 9", note);
    end
    p0 = pulse_cnt;
    // Last rise was 1136 negedges ago; the counter restarted 4 clk after it.
    repeat (8196 - 1136) @(negedge clk);
    total++;
    if (note !== 4'd9) begin
      bad++;
      $display("FAIL silence_early: note=%0d want 9", note);
    end
    @(negedge clk);
    total++;
    if (note !== 4'd0 || note_change !== 1'b1) begin
      bad++;
      $display("FAIL silence_drop: note=%0d chg=%b want 0 1", note, note_change);
    end
    repeat (100) @(negedge clk);
    total++;
    if (note_valid !== 1'b0 || period !== 22'd1136) begin
      bad++;
      $display("FAIL silence_hold: valid=%b period=%0d want 0 1136", note_valid, period);
    end
    total++;
    if (pulse_cnt - p0 !== 1) begin
      bad++;
      $display("FAIL silence_pulses: got %0d want 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_reset_relock;
    tone_periods(1136, 4);
    total++;
    if (note !== 4'd9) begin
      bad++;
      $display("FAIL relock_pre: note=%0d want 9", note);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (note !== 4'd0 || note_valid !== 1'b0 || note_change !== 1'b0 || period !== '0) begin
      bad++;
      $display("FAIL relock_reset: note=%0d valid=%b chg=%b period=%0d want all 0",
               note, note_valid, note_change, period);
    end
    tone_periods(1136, 1);
    total++;
    if (period !== '0 || note !== 4'd0) begin
      bad++;
      $display("FAIL relock_first_rise: period=%0d note=%0d want 0 0", period, note);
    end
    tone_periods(1136, 2);
    total++;
    if (period !== 22'd1136 || note !== 4'd0) begin
      bad++;
      $display("FAIL relock_partial: period=%0d note=%0d want 1136 0", period, note);
    end
    tone_in = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (note !== 4'd0) begin
      bad++;
      $display("FAIL relock_lat_before: note=%0d want 0", note);
    end
    @(negedge clk);
    total++;
    if (note !== 4'd9 || note_change !== 1'b1) begin
      bad++;
      $display("FAIL relock_lat: note=%0d chg=%b want 9 1", note, note_change);
    end
    repeat (568 - 5) @(negedge clk);
    tone_in = 1'b0;
    repeat (568) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_hysteresis();
    test_switch();
    test_silence();
    test_reset_relock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
